// File: rtl/fib_counter_display_if.sv
// Pin bundle for fib_counter_display: count controls in, counter/display outputs out.
interface fib_counter_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2
);
    logic              en;
    logic              clr;
    logic [WIDTH-1:0]  count;
    logic              fib;
    logic [6:0]        sevenSeg;
    logic [DIGITS-1:0] an;

    modport master (output en, clr, input count, fib, sevenSeg, an);
    modport slave  (input en, clr, output count, fib, sevenSeg, an);
endinterface

// File: rtl/fib_counter_display.sv
// Prescaled WIDTH-bit counter with Fibonacci flag driving a multiplexed hex display.
// Optional leading-zero blanking when FIB_COUNTER_DISPLAY_BLANK_EN is defined.
module fib_counter_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    fib_counter_display_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NW = 4 * DIGITS;
    localparam int EW = (NW > WIDTH) ? NW : WIDTH;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
    localparam logic [6:0]    GLYPH_ZERO = 7'b1000000;

    logic [PW-1:0]     presc_q, presc_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              fib_q, fib_d;
    logic [WIDTH:0]    a_q, a_d, b_q, b_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [WIDTH-1:0]  cn;
    logic [WIDTH+1:0]  sum;
    logic [EW-1:0]     cnt_ext;
    logic [3:0]        nibble;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Counter and Fibonacci tracker: b is always the next Fibonacci value above count.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        fib_d   = fib_q;
        a_d     = a_q;
        b_d     = b_q;
        cn      = '0;
        sum     = '0;
        if (bus.clr) begin
            presc_d = '0;
            count_d = '0;
            fib_d   = 1'b1;
            a_d     = (WIDTH+1)'(1);
            b_d     = (WIDTH+1)'(2);
        end else if (bus.en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                cn      = count_q + 1'b1;
                count_d = cn;
                if (cn == '0) begin
                    a_d   = (WIDTH+1)'(1);
                    b_d   = (WIDTH+1)'(2);
                    fib_d = 1'b1;
                end else begin
                    if ({1'b0, cn} == b_q) begin
                        sum = {1'b0, a_q} + {1'b0, b_q};
                        a_d = b_q;
                        b_d = sum[WIDTH+1] ? '1 : sum[WIDTH:0];
                    end
                    fib_d = (cn < WIDTH'(2)) || ({1'b0, cn} == b_q);
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Digit slot and its glyph are latched together at each slot boundary.
    always_comb begin
        scan_d  = scan_q + 1'b1;
        dig_d   = dig_q;
        an_d    = an_q;
        seg_d   = seg_q;
        cnt_ext = EW'(count_q);
        nibble  = '0;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
            an_d   = ~(DIGITS'(1) << dig_d);
            nibble = cnt_ext[4*dig_d +: 4];
            seg_d  = glyph(nibble);
`ifdef FIB_COUNTER_DISPLAY_BLANK_EN
            if ((dig_d != '0) && ((cnt_ext >> (4*dig_d)) == '0))
                seg_d = '1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= '0;
            fib_q   <= 1'b1;
            a_q     <= (WIDTH+1)'(1);
            b_q     <= (WIDTH+1)'(2);
            scan_q  <= '0;
            dig_q   <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= GLYPH_ZERO;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            fib_q   <= fib_d;
            a_q     <= a_d;
            b_q     <= b_d;
            scan_q  <= scan_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.fib      = fib_q;
    assign bus.an       = an_q;
    assign bus.sevenSeg = seg_q;
endmodule

// File: tb/tb_fib_counter_display.sv
// Randomised self-checking bench for fib_counter_display against a behavioural model.
module tb_fib_counter_display;
    localparam int WIDTH    = 8;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 3;
    localparam int SCAN_DIV = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errs;
    logic chk_on;

    logic [6:0] glyph_tab [16];

    int m_presc;
    int m_count;
    int m_edges;
    int m_dig;
    logic [6:0] m_seg;

    fib_counter_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    fib_counter_display #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_fib(input int n);
        int x, y, t;
        if (n < 2) return 1'b1;
        x = 1;
        y = 2;
        while (y <= n) begin
            if (y == n) return 1'b1;
            t = x + y;
            x = y;
            y = t;
        end
        return 1'b0;
    endfunction

    function automatic logic [6:0] exp_glyph(input int cnt, input int d);
        int hi;
        hi = cnt >> (4 * d);
`ifdef FIB_COUNTER_DISPLAY_BLANK_EN
        if (d > 0 && hi == 0) return 7'b1111111;
`endif
        return glyph_tab[hi & 15];
    endfunction

    function automatic logic [DIGITS-1:0] exp_an(input int d);
        logic [DIGITS-1:0] v;
        v = '1;
        v[d] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_presc = 0;
        m_count = 0;
        m_edges = 0;
        m_dig   = 0;
        m_seg   = glyph_tab[0];
    endtask

    // One clock: drive inputs on the falling edge, advance the model on the rising edge.
    task automatic step(input logic e, input logic c, input logic r = 1'b1);
        int prev;
        @(negedge clk);
        bus.en  = e;
        bus.clr = c;
        reset   = r;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            prev = m_count;
            m_edges++;
            if (c) begin
                m_presc = 0;
                m_count = 0;
            end else if (e) begin
                if (m_presc == TICK_DIV - 1) begin
                    m_presc = 0;
                    m_count = (m_count + 1) % (1 << WIDTH);
                end else begin
                    m_presc++;
                end
            end
            if (m_edges % SCAN_DIV == 0) begin
                m_dig = (m_edges / SCAN_DIV) % DIGITS;
                m_seg = exp_glyph(prev, m_dig);
            end
        end
    endtask

    task automatic run_to(input int target, input logic exp_fib);
        int budget;
        budget = 2 * (1 << WIDTH) * TICK_DIV;
        while (m_count != target && budget > 0) begin
            step(1'b1, 1'b0);
            budget--;
        end
        #1;
        chk($sformatf("reach_%0d", target), 32'(m_count), 32'(target));
        chk($sformatf("fib_at_%0d", target), 32'(bus.fib), 32'(exp_fib));
    endtask

    task automatic display_check(input logic [6:0] seg_lo, input logic [6:0] seg_hi);
        for (int i = 0; i < SCAN_DIV * (DIGITS + 1); i++) step(1'b0, 1'b0);
        for (int i = 0; i < 2 * SCAN_DIV * DIGITS; i++) begin
            step(1'b0, 1'b0);
            #1;
            if (bus.an == 2'b10) chk("disp_lo", 32'(bus.sevenSeg), 32'(seg_lo));
            else                 chk("disp_hi", 32'(bus.sevenSeg), 32'(seg_hi));
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("count", 32'(bus.count), 32'(m_count));
            chk("fib", 32'(bus.fib), 32'(is_fib(m_count)));
            chk("an", 32'(bus.an), 32'(exp_an(m_dig)));
            chk("seg", 32'(bus.sevenSeg), 32'(m_seg));
        end
    end

    initial begin
        n_checks = 0;
        n_errs   = 0;
        chk_on   = 1'b0;
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();
        reset   = 1'b0;
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        chk_on  = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_fib", 32'(bus.fib), 32'd1);
        chk("rst_an", 32'(bus.an), 32'b10);
        chk("rst_seg", 32'(bus.sevenSeg), 32'b1000000);

        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        #1;
        chk("hold_count", 32'(bus.count), 32'd0);

        run_to(5, 1'b1);
`ifdef FIB_COUNTER_DISPLAY_BLANK_EN
        display_check(7'b0010010, 7'b1111111);
`else
        display_check(7'b0010010, 7'b1000000);
`endif

        run_to(7, 1'b0);
        while (m_presc != TICK_DIV - 1) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        #1;
        chk("clr_count", 32'(bus.count), 32'd0);
        chk("clr_fib", 32'(bus.fib), 32'd1);
        run_to(1, 1'b1);
        run_to(2, 1'b1);
        run_to(3, 1'b1);
        run_to(4, 1'b0);

        run_to(8'h3A, 1'b0);
        display_check(7'b0001000, 7'b0110000);

        run_to(144, 1'b1);
        run_to(200, 1'b0);
        run_to(233, 1'b1);
        run_to(255, 1'b0);
        run_to(0, 1'b1);
        run_to(1, 1'b1);
        run_to(4, 1'b0);
        run_to(5, 1'b1);
        run_to(13, 1'b1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 2);

        run_to(21, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_fib", 32'(bus.fib), 32'd1);
        chk("async_an", 32'(bus.an), 32'b10);
        chk("async_seg", 32'(bus.sevenSeg), 32'b1000000);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
